// File: rtl/fix16_pkg.sv
// Shared definitions for the fixed-point unit issuer: op codes, saturation
// limits, issuer FSM states and the op-to-enable decode.
package fix16_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [15:0] FIX_MAX = 16'h7FFF;
  localparam logic [15:0] FIX_MIN = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  function automatic logic [3:0] op_onehot(input logic [1:0] op);
    return 4'b0001 << op;
  endfunction

endpackage

// File: rtl/fix16_op_issuer.sv
// Issues one request to a fixed-point unit over the en/done handshake and
// returns the captured result (or a saturated/timeout error) as a response.
module fix16_op_issuer
  import fix16_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [3:0]  unit_en,
  output logic [15:0] unit_a,
  output logic [15:0] unit_b,
  input  logic [3:0]  unit_done,
  input  logic [63:0] unit_out,
  output state_t      dbg_state
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TIMEOUT);

  state_t      state;
  logic [1:0]  op_q;
  logic [CW-1:0] cnt;
  logic        done_sel;
  logic [15:0] out_sel;

  // Valid/ready: a transfer happens on a rising clk edge where both are high;
  // valid never depends on ready, and payload is held stable while valid waits.
  assign req_ready = (state == ST_IDLE) && !rst;
  assign dbg_state = state;
  assign done_sel  = unit_done[op_q];
  assign out_sel   = unit_out[{op_q, 4'b0000} +: 16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      cnt       <= '0;
      unit_en   <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            unit_a  <= req_a;
            unit_b  <= req_b;
            cnt     <= '0;
            rsp_err <= 1'b0;
            // Divide-by-zero never reaches a unit; answer with a saturated value.
            if (req_op == OP_DIV && req_b == 16'h0000) begin
              rsp_err   <= 1'b1;
              rsp_data  <= req_a[15] ? FIX_MIN : FIX_MAX;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              unit_en <= op_onehot(req_op);
              state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
          if (done_sel) begin
            state <= ST_SETTLE;
          end else if (cnt >= CNT_LAST) begin
            unit_en  <= '0;
            cnt      <= '0;
            rsp_err  <= 1'b1;
            rsp_data <= '0;
            state    <= ST_DRAIN;
          end
        end
        ST_SETTLE: begin
          // Second done cycle: the unit may have refined its output on the first.
          if (!done_sel) begin
            state <= ST_WAIT;
          end else begin
            rsp_data <= out_sel;
            unit_en  <= '0;
            cnt      <= '0;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!done_sel) begin
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (cnt >= CNT_LAST) begin
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix16_op_issuer.sv
// Bench for fix16_op_issuer: vector table, scripted multi-cycle unit
// responders, randomized ops against a reference model, and a TIMEOUT=8 copy.
module tb_fix16_op_issuer;
  import fix16_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (TIMEOUT=64) ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [15:0] req_a = 16'h0, req_b = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  unit_en, unit_done;
  logic [15:0] unit_a, unit_b;
  logic [63:0] unit_out;
  state_t      dbg_state;

  fix16_op_issuer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .unit_en(unit_en), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_out(unit_out), .dbg_state(dbg_state)
  );

  // Bench arithmetic units: combinational (done = en) unless a scripted responder is active.
  logic               manual = 1'b0;
  logic [3:0]         man_done = 4'h0;
  logic [63:0]        man_out = 64'h0;
  logic [63:0]        man_map = 64'h0;
  logic [1:0]         man_op = 2'd0;
  logic [15:0]        man_out1 = 16'h0, man_out2 = 16'h0;
  logic signed [31:0] prod;
  logic signed [23:0] num;
  logic [15:0]        q_div;
  logic [63:0]        comb_out;

  assign prod      = $signed(unit_a) * $signed(unit_b);
  assign num       = {unit_a, 8'h00};
  assign q_div     = (unit_b == 16'h0) ? 16'h0 : 16'(num / $signed(unit_b));
  assign comb_out  = {q_div, prod[23:8], unit_a - unit_b, unit_a + unit_b};
  assign unit_done = manual ? man_done : unit_en;
  assign unit_out  = manual ? man_out : comb_out;

  // ---------------- second DUT (TIMEOUT=8) ----------------
  logic        t8_req_valid = 1'b0;
  logic        t8_req_ready;
  logic [1:0]  t8_req_op = 2'd0;
  logic [15:0] t8_req_a = 16'h0, t8_req_b = 16'h0;
  logic        t8_rsp_valid;
  logic        t8_rsp_ready = 1'b0;
  logic [15:0] t8_rsp_data;
  logic        t8_rsp_err;
  logic [3:0]  t8_unit_en;
  logic [3:0]  t8_done = 4'h0;
  logic [15:0] t8_unit_a, t8_unit_b;
  logic [63:0] t8_out = 64'h5555_5555_5555_5555;
  state_t      t8_dbg;

  fix16_op_issuer #(.TIMEOUT(8)) dut_t8 (
    .clk(clk), .rst(rst),
    .req_valid(t8_req_valid), .req_ready(t8_req_ready), .req_op(t8_req_op),
    .req_a(t8_req_a), .req_b(t8_req_b),
    .rsp_valid(t8_rsp_valid), .rsp_ready(t8_rsp_ready), .rsp_data(t8_rsp_data), .rsp_err(t8_rsp_err),
    .unit_en(t8_unit_en), .unit_a(t8_unit_a), .unit_b(t8_unit_b),
    .unit_done(t8_done), .unit_out(t8_out), .dbg_state(t8_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        err;
    int          lat;
    int          en;
    int          hold;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result of the requested Q8.8 operation on the request operands.
  function automatic logic [16:0] ref_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0;
    case (op)
      2'd0: r = sa + sb;
      2'd1: r = sa - sb;
      2'd2: r = (sa * sb) >>> 8;
      default: begin
        if (sb == 0) return {1'b1, (a[15] ? 16'h8000 : 16'h7FFF)};
        r = (sa * 256) / sb;
      end
    endcase
    return {1'b0, r[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_man(input int c);
    logic cur, prev;
    if (!manual) return;
    cur  = (c >= 0 && c < 64) ? man_map[c] : 1'b0;
    prev = (c >= 1 && c < 65) ? man_map[c-1] : 1'b0;
    man_done = cur ? op_onehot(man_op) : 4'h0;
    man_out  = {4{cur ? (prev ? man_out2 : man_out1) : 16'hDEAD}};
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin step(); w++; end
    chk("req_ready_before_accept", req_ready, 1);
    drive_man(0);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    step();
    req_valid = 1'b0;
  endtask

  // Returns the cycle (accept = 0) at which rsp_valid is seen, plus en activity.
  task automatic wait_rsp(input logic [1:0] op, output int lat, output int en_cnt, output int stray);
    lat = 1; en_cnt = 0; stray = 0;
    drive_man(1);
    while (!rsp_valid && lat < 200) begin
      if (unit_en != 4'h0) begin
        en_cnt++;
        if (unit_en != op_onehot(op)) stray++;
      end
      step();
      lat++;
      drive_man(lat);
    end
  endtask

  task automatic finish_rsp(input int hold, input logic [15:0] d, input logic e, input string name);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({name, "_hold_valid"}, rsp_valid, 1);
      chk({name, "_hold_data"}, rsp_data, d);
      chk({name, "_hold_err"}, rsp_err, e);
      chk({name, "_hold_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({name, "_valid_drop"}, rsp_valid, 0);
    chk({name, "_ready_back"}, req_ready, 1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] d, input logic e, input int lat_exp, input int en_exp,
                        input int hold, input string name);
    int lat, en_cnt, stray;
    issue(op, a, b);
    wait_rsp(op, lat, en_cnt, stray);
    chk({name, "_latency"}, lat, lat_exp);
    chk({name, "_en_cycles"}, en_cnt, en_exp);
    chk({name, "_en_stray"}, stray, 0);
    chk({name, "_data"}, rsp_data, d);
    chk({name, "_err"}, rsp_err, e);
    chk({name, "_unit_a"}, unit_a, a);
    chk({name, "_unit_b"}, unit_b, b);
    finish_rsp(hold, d, e, name);
  endtask

  task automatic t8_run(input logic [1:0] op, input int lat_exp, input int en_exp, input string name);
    int w, lat, en_cnt, stray;
    w = 0;
    while (!t8_req_ready && w < 50) begin step(); w++; end
    t8_req_valid = 1'b1; t8_req_op = op; t8_req_a = 16'h0100; t8_req_b = 16'h0200;
    step();
    t8_req_valid = 1'b0;
    lat = 1; en_cnt = 0; stray = 0;
    while (!t8_rsp_valid && lat < 60) begin
      if (t8_unit_en != 4'h0) begin
        en_cnt++;
        if (t8_unit_en != op_onehot(op)) stray++;
      end
      step();
      lat++;
    end
    chk({name, "_latency"}, lat, lat_exp);
    chk({name, "_en_cycles"}, en_cnt, en_exp);
    chk({name, "_en_stray"}, stray, 0);
    chk({name, "_data"}, t8_rsp_data, 16'h0000);
    chk({name, "_err"}, t8_rsp_err, 1);
    t8_rsp_ready = 1'b1;
    step();
    t8_rsp_ready = 1'b0;
    chk({name, "_valid_drop"}, t8_rsp_valid, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int lat, en_cnt, stray, seen;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [16:0] e;
    logic        dbz;

    //          op     a         b         data      err   lat en hold
    vecs[0] = '{2'd0, 16'h0180, 16'h0100, 16'h0280, 1'b0, 4, 2, 0};
    vecs[1] = '{2'd1, 16'h0100, 16'h0180, 16'hFF80, 1'b0, 4, 2, 1};
    vecs[2] = '{2'd2, 16'h0200, 16'h0300, 16'h0600, 1'b0, 4, 2, 0};
    vecs[3] = '{2'd2, 16'hFF00, 16'h0200, 16'hFE00, 1'b0, 4, 2, 2};
    vecs[4] = '{2'd3, 16'h0600, 16'h0200, 16'h0300, 1'b0, 4, 2, 0};
    vecs[5] = '{2'd3, 16'hFF00, 16'h0000, 16'h8000, 1'b1, 1, 0, 0};
    vecs[6] = '{2'd3, 16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1, 0, 3};
    vecs[7] = '{2'd3, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1, 0, 0};
    vecs[8] = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 4, 2, 0};
    vecs[9] = '{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 4, 2, 1};

    // Reset values, applied asynchronously before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_unit_en", unit_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_unit_b", unit_b, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    step(); step();
    rst = 1'b0;
    step();
    chk("ready_after_reset", req_ready, 1);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].err,
             vecs[i].lat, vecs[i].en, vecs[i].hold, $sformatf("vec%0d", i));

    // Slow DIV: done at cycle 17, result refined on second done cycle, done lingers one cycle.
    manual = 1'b1; man_op = 2'd3; man_done = 4'h0;
    man_map = 64'h0; man_map[17] = 1'b1; man_map[18] = 1'b1; man_map[19] = 1'b1;
    man_out1 = 16'h1111; man_out2 = 16'h2222;
    run_op(2'd3, 16'h2000, 16'h0100, 16'h2222, 1'b0, 21, 18, 0, "div_slow");

    // Done drops during SETTLE: issuer must go back to waiting and capture later.
    man_op = 2'd0; man_done = 4'h0;
    man_map = 64'h0; man_map[3] = 1'b1; man_map[7] = 1'b1; man_map[8] = 1'b1;
    man_out1 = 16'h0BAD; man_out2 = 16'h1234;
    run_op(2'd0, 16'h0001, 16'h0001, 16'h1234, 1'b0, 10, 8, 1, "settle_glitch");
    manual = 1'b0;

    // Backpressure on the response with a second request already waiting.
    issue(2'd0, 16'h0001, 16'h0002);
    wait_rsp(2'd0, lat, en_cnt, stray);
    chk("bp_first_latency", lat, 4);
    req_valid = 1'b1; req_op = 2'd1; req_a = 16'h0005; req_b = 16'h0003;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 16'h0003);
      chk("bp_err", rsp_err, 0);
      chk("bp_req_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_ready_after_hs", req_ready, 1);
    chk("bp_valid_after_hs", rsp_valid, 0);
    step();
    req_valid = 1'b0;
    chk("b2b_accepted_ready", req_ready, 0);
    chk("b2b_accepted_en", unit_en, 4'b0010);
    wait_rsp(2'd1, lat, en_cnt, stray);
    chk("b2b_latency", lat, 4);
    chk("b2b_data", rsp_data, 16'h0002);
    chk("b2b_err", rsp_err, 0);
    finish_rsp(0, 16'h0002, 1'b0, "b2b");

    // Randomized ops checked against the reference model through the expected queue.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      dbz = (op == 2'd3) && (b == 16'h0000);
      exp_q.push_back(ref_model(op, a, b));
      e = exp_q.pop_front();
      run_op(op, a, b, e[15:0], e[16], dbz ? 1 : 4, dbz ? 0 : 2,
             int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    // Reset while waiting on a DIV unit that never answers.
    manual = 1'b1; man_op = 2'd3; man_map = 64'h0; man_done = 4'h0;
    issue(2'd3, 16'h0100, 16'h0100);
    step(); step();
    chk("midrst_en_before", unit_en, 4'b1000);
    chk("midrst_state_before", dbg_state, ST_WAIT);
    #1 rst = 1'b1;
    #1;
    chk("midrst_en_now", unit_en, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_unit_a", unit_a, 0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("midrst_no_response", seen, 0);
    chk("midrst_ready_after", req_ready, 1);
    manual = 1'b0;
    run_op(2'd0, 16'h0180, 16'h0100, 16'h0280, 1'b0, 4, 2, 0, "add_after_reset");

    // TIMEOUT=8 instance: never-done unit, then a done that never clears.
    t8_done = 4'h0;
    t8_run(2'd2, 10, 8, "t8_wait_timeout");
    t8_done = 4'b0100;
    t8_run(2'd2, 11, 2, "t8_drain_timeout");
    t8_done = 4'h0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
